// File: rtl/bcd_stopwatch_if.sv
// Push-button / display bundle between the board front panel and bcd_stopwatch_ctrl.
// The front panel drives the master side; the controller takes the slave side.
interface bcd_stopwatch_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      start_stop;
    logic                      lap;
    logic                      clear;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic                      running;
    logic                      lap_active;
    logic                      tick;
    logic                      overflow;

    modport master (
        output start_stop, lap, clear,
        input  digits, running, lap_active, tick, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
        output digits, running, lap_active, tick, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Single-clock stopwatch: prescaler tick, cascaded BCD count, start/stop/lap/clear FSM.
// Optional macro BCD_STOPWATCH_SATURATE_EN: hold at all-9s and pause instead of wrapping.
module bcd_stopwatch_ctrl #(
    parameter int PRESCALE_MAX = 49999999,
    parameter int PRESCALE_W   = 26,
    parameter int NUM_DIGITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_stopwatch_ctrl_if.slave  bus
);
    localparam int                    DW   = 4 * NUM_DIGITS;
    localparam logic [PRESCALE_W-1:0] PMAX = PRESCALE_W'(PRESCALE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_t;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [DW-1:0]         r_count;
    logic [DW-1:0]         r_lap;
    logic                  r_ovf;
    logic                  r_tick;
    logic                  r_running;
    logic                  r_lap_active;
    logic                  r_ss_d;
    logic                  r_lap_d;
    logic                  r_clr_d;

    logic                  w_ss_ev;
    logic                  w_lap_ev;
    logic                  w_clr_ev;
    logic                  w_wrap;
    logic [DW-1:0]         w_cnt_inc;
    logic                  w_carry;
    logic                  w_all9;

    assign w_ss_ev  = bus.start_stop & ~r_ss_d;
    assign w_lap_ev = bus.lap        & ~r_lap_d;
    assign w_clr_ev = bus.clear      & ~r_clr_d;
    assign w_wrap   = r_running && (r_presc == PMAX);

    // Ripple the +1 through the digits; the carry out of the top digit means all-9s.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_cnt_inc = r_count;
        w_carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
        w_all9 = w_carry;
    end

`ifdef BCD_STOPWATCH_SATURATE_EN
    logic w_sat;
    assign w_sat = w_wrap && w_all9;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_count      <= '0;
            r_lap        <= '0;
            r_ovf        <= 1'b0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_ss_d       <= 1'b0;
            r_lap_d      <= 1'b0;
            r_clr_d      <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment; where two assignments hit one register, the later one wins.
            r_ss_d  <= bus.start_stop;
            r_lap_d <= bus.lap;
            r_clr_d <= bus.clear;
            r_tick  <= w_wrap;

            if (r_running) begin
                r_presc <= w_wrap ? '0 : r_presc + PRESCALE_W'(1);
            end

            if (w_wrap) begin
                if (w_all9) begin
                    r_ovf <= 1'b1;
                end
`ifdef BCD_STOPWATCH_SATURATE_EN
                if (!w_all9) begin
                    r_count <= w_cnt_inc;
                end
`else
                r_count <= w_cnt_inc;
`endif
            end

            // Clear overrides the tick update above on the same edge.
            if (w_clr_ev) begin
                r_state      <= S_IDLE;
                r_running    <= 1'b0;
                r_lap_active <= 1'b0;
                r_presc      <= '0;
                r_count      <= '0;
                r_lap        <= '0;
                r_ovf        <= 1'b0;
            end
`ifdef BCD_STOPWATCH_SATURATE_EN
            else if (w_sat) begin
                r_state      <= S_PAUSE;
                r_running    <= 1'b0;
                r_lap_active <= 1'b0;
            end
`endif
            else if (w_ss_ev) begin
                case (r_state)
                    S_IDLE, S_PAUSE: begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                    default: begin
                        r_state      <= S_PAUSE;
                        r_running    <= 1'b0;
                        r_lap_active <= 1'b0;
                    end
                endcase
            end else if (w_lap_ev) begin
                case (r_state)
                    S_RUN: begin
                        r_state      <= S_LAP;
                        r_lap_active <= 1'b1;
                        r_lap        <= r_count;
                    end
                    S_LAP: begin
                        r_state      <= S_RUN;
                        r_lap_active <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.digits     = r_lap_active ? r_lap : r_count;
    assign bus.running    = r_running;
    assign bus.lap_active = r_lap_active;
    assign bus.tick       = r_tick;
    assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl with PRESCALE_MAX=3, NUM_DIGITS=4.
// An integer-valued reference model pushes expected outputs per clock; the monitor pops and compares.
module tb_bcd_stopwatch_ctrl;
    localparam int PMAX = 3;
    localparam int MAXC = 9999;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl_if #(.NUM_DIGITS(4)) sw_if ();

    bcd_stopwatch_ctrl #(
        .PRESCALE_MAX (PMAX),
        .PRESCALE_W   (2),
        .NUM_DIGITS   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mstate_t;

    typedef struct {
        logic [15:0] digits;
        bit          running;
        bit          lap_active;
        bit          tick;
        bit          overflow;
    } exp_t;

    exp_t    exp_q[$];
    int      n_total = 0;
    int      n_bad   = 0;

    mstate_t m_st;
    int      m_presc, m_count, m_lap;
    bit      m_ovf, m_tick, h_ss, h_lp, h_cl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_step();
        bit e_ss, e_lp, e_cl, run, wrap, sat;
        int old_count;
        exp_t e;
        if (rst) begin
            m_st = M_IDLE; m_presc = 0; m_count = 0; m_lap = 0;
            m_ovf = 0; m_tick = 0; h_ss = 0; h_lp = 0; h_cl = 0;
        end else begin
            e_ss = sw_if.start_stop && !h_ss;
            e_lp = sw_if.lap        && !h_lp;
            e_cl = sw_if.clear      && !h_cl;
            h_ss = sw_if.start_stop;
            h_lp = sw_if.lap;
            h_cl = sw_if.clear;
            old_count = m_count;
            run  = (m_st == M_RUN) || (m_st == M_LAP);
            wrap = run && (m_presc == PMAX);
            m_tick = wrap;
            sat = 0;
            if (run) m_presc = wrap ? 0 : m_presc + 1;
            if (wrap) begin
                if (m_count == MAXC) begin
                    m_ovf = 1;
`ifdef BCD_STOPWATCH_SATURATE_EN
                    sat = 1;
`else
                    m_count = 0;
`endif
                end else begin
                    m_count = m_count + 1;
                end
            end
            if (e_cl) begin
                m_st = M_IDLE; m_presc = 0; m_count = 0; m_lap = 0; m_ovf = 0;
            end else if (sat) begin
                m_st = M_PAUSE;
            end else if (e_ss) begin
                m_st = (m_st == M_IDLE || m_st == M_PAUSE) ? M_RUN : M_PAUSE;
            end else if (e_lp) begin
                if (m_st == M_RUN) begin
                    m_st  = M_LAP;
                    m_lap = old_count;
                end else if (m_st == M_LAP) begin
                    m_st = M_RUN;
                end
            end
        end
        e.digits     = (m_st == M_LAP) ? to_bcd(m_lap) : to_bcd(m_count);
        e.running    = (m_st == M_RUN) || (m_st == M_LAP);
        e.lap_active = (m_st == M_LAP);
        e.tick       = m_tick;
        e.overflow   = m_ovf;
        exp_q.push_back(e);
    endtask

    // Drive one edge: push expectation, clock, then compare on the falling edge.
    task automatic clk_step();
        exp_t e;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("digits",     32'(sw_if.digits),     32'(e.digits));
        check("running",    32'(sw_if.running),    32'(e.running));
        check("lap_active", 32'(sw_if.lap_active), 32'(e.lap_active));
        check("tick",       32'(sw_if.tick),       32'(e.tick));
        check("overflow",   32'(sw_if.overflow),   32'(e.overflow));
    endtask

    task automatic pulse(input bit s, input bit l, input bit c);
        sw_if.start_stop = s;
        sw_if.lap        = l;
        sw_if.clear      = c;
        clk_step();
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
    endtask

    task automatic run_until_count(input int target, input string tag);
        int n;
        n = 0;
        while (m_count != target && n < 60000) begin
            clk_step();
            n++;
        end
        check(tag, 32'(m_count), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n_chg;
        bit prev;
        rst              = 1'b1;
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        repeat (2) clk_step();
        rst = 1'b0;
        clk_step();
        check("rst_digits",  32'(sw_if.digits),  32'h0);
        check("rst_running", 32'(sw_if.running), 32'h0);

        // Start: running on the next edge, first tick four edges later.
        pulse(1, 0, 0);
        check("start_running", 32'(sw_if.running), 32'h1);
        repeat (3) clk_step();
        check("pre_tick", 32'(sw_if.tick), 32'h0);
        clk_step();
        check("tick1", 32'(sw_if.tick), 32'h1);
        check("cnt1",  32'(sw_if.digits), 32'h0001);
        repeat (3) clk_step();
        check("gap_tick", 32'(sw_if.tick), 32'h0);
        clk_step();
        check("tick2", 32'(sw_if.tick), 32'h1);
        check("cnt2",  32'(sw_if.digits), 32'h0002);

        run_until_count(9, "reach9");
        check("cnt9", 32'(sw_if.digits), 32'h0009);
        run_until_count(10, "reach10");
        check("cnt10", 32'(sw_if.digits), 32'h0010);

        // Lap freezes the display while counting continues.
        run_until_count(12, "reach12");
        pulse(0, 1, 0);
        check("lap_on",  32'(sw_if.lap_active), 32'h1);
        check("lap_val", 32'(sw_if.digits), 32'h0012);
        repeat (20) clk_step();
        check("lap_hold", 32'(sw_if.digits), 32'h0012);
        pulse(0, 1, 0);
        check("lap_off",  32'(sw_if.lap_active), 32'h0);
        check("lap_live", 32'(sw_if.digits), 32'h0017);

        run_until_count(99, "reach99");
        check("cnt99", 32'(sw_if.digits), 32'h0099);
        run_until_count(100, "reach100");
        check("cnt100", 32'(sw_if.digits), 32'h0100);

        // Pause two cycles after a tick; prescaler must resume from its held value.
        run_until_count(101, "reach101");
        clk_step();
        pulse(1, 0, 0);
        check("paused", 32'(sw_if.running), 32'h0);
        repeat (20) clk_step();
        check("pause_hold", 32'(sw_if.digits), 32'h0101);
        pulse(1, 0, 0);
        clk_step();
        check("resume_no_tick", 32'(sw_if.tick), 32'h0);
        clk_step();
        check("resume_tick", 32'(sw_if.tick), 32'h1);
        check("resume_cnt",  32'(sw_if.digits), 32'h0102);

        // Roll past all-9s.
        run_until_count(MAXC, "reach9999");
        check("cnt9999", 32'(sw_if.digits), 32'h9999);
        repeat (4) clk_step();
        check("ovf_set", 32'(sw_if.overflow), 32'h1);
`ifdef BCD_STOPWATCH_SATURATE_EN
        check("sat_digits",  32'(sw_if.digits),  32'h9999);
        check("sat_running", 32'(sw_if.running), 32'h0);
        pulse(1, 0, 0);
        check("sat_restart", 32'(sw_if.running), 32'h1);
        repeat (4) clk_step();
        check("sat_again",   32'(sw_if.digits),  32'h9999);
        check("sat_paused",  32'(sw_if.running), 32'h0);
        pulse(1, 0, 0);
`else
        check("wrap_digits",  32'(sw_if.digits),  32'h0000);
        check("wrap_running", 32'(sw_if.running), 32'h1);
        repeat (8) clk_step();
        check("ovf_sticky", 32'(sw_if.overflow), 32'h1);
        check("wrap_cnt2",  32'(sw_if.digits),   32'h0002);
`endif

        // start_stop and clear together: clear wins.
        clk_step();
        pulse(1, 0, 1);
        check("clr_running", 32'(sw_if.running),  32'h0);
        check("clr_digits",  32'(sw_if.digits),   32'h0);
        check("clr_ovf",     32'(sw_if.overflow), 32'h0);
        pulse(0, 1, 0);
        check("idle_lap_ignored", 32'(sw_if.lap_active), 32'h0);

        // A held start_stop yields exactly one state change.
        n_chg = 0;
        sw_if.start_stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            prev = sw_if.running;
            clk_step();
            if (sw_if.running != prev) n_chg++;
        end
        sw_if.start_stop = 1'b0;
        check("hold_changes", 32'(n_chg), 32'd1);
        check("hold_running", 32'(sw_if.running), 32'h1);

        // Lap is ignored while paused.
        clk_step();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("pause_lap_ignored", 32'(sw_if.lap_active), 32'h0);
        check("pause_running",     32'(sw_if.running),    32'h0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
